// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: load-busy scoreboard plus decode/fetch/EX stall and flush sequencing.
// The decode instruction is held on a RAW/WAW conflict with a pending load. Decode and EX are
// flushed on a taken branch. The back end is frozen on a memory stall.
// Optional feature: define HAZARD_PERF_EN to build a saturating stall-cycle counter
// (stall_cnt_out). Otherwise stall_cnt_out is tied to zero.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned PERF_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_BITS-1:0]   rs1_D_in,
  input  logic [REG_BITS-1:0]   rs2_D_in,
  input  logic [REG_BITS-1:0]   rd_D_in,
  input  logic                  reg_write_D_in,
  input  logic                  long_lat_D_in,
  input  logic                  branch_taken_E_in,
  input  logic                  mem_stall_in,
  input  logic [REG_BITS-1:0]   rd_WB_in,
  input  logic                  reg_write_WB_in,
  output logic                  stall_fd_out,
  output logic                  stall_ex_out,
  output logic                  flush_d_out,
  output logic                  flush_e_out,
  output logic [1:0]            state_out,
  output logic [NUM_REGS-1:0]   busy_out,
  output logic [PERF_WIDTH-1:0] stall_cnt_out
);

  typedef enum logic [1:0] {
    StRun = 2'd0,
    StRaw = 2'd1,
    StMem = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                hazard;
  logic                issue;

  // Conservative conflict check: both sources always looked at, plus WAW on the destination.
  always_comb begin
    hazard = busy_q[rs1_D_in] | busy_q[rs2_D_in] | (reg_write_D_in & busy_q[rd_D_in]);
  end

  // Prioritised control decision; the next FSM state follows the same priority.
  always_comb begin
    stall_fd_out = 1'b0;
    stall_ex_out = 1'b0;
    flush_d_out  = 1'b0;
    flush_e_out  = 1'b0;
    state_d      = StRun;
    if (reset) begin
      state_d = StRun;
    end else if (mem_stall_in) begin
      // EX is frozen, so a taken branch there will re-assert once the stall clears.
      stall_fd_out = 1'b1;
      stall_ex_out = 1'b1;
      state_d      = StMem;
    end else if (branch_taken_E_in) begin
      // The decode instruction is being discarded, so its hazard does not matter.
      flush_d_out = 1'b1;
      flush_e_out = 1'b1;
      state_d     = StRun;
    end else if (hazard) begin
      stall_fd_out = 1'b1;
      flush_e_out  = 1'b1;
      state_d      = StRaw;
    end
  end

  assign issue = ~reset & ~stall_fd_out & ~flush_d_out;

  // Scoreboard next state: WB clear first, so a same-index load issue overrides it.
  always_comb begin
    busy_d = busy_q;
    if (reset) begin
      busy_d = '0;
    end else begin
      if (reg_write_WB_in && !mem_stall_in) begin
        busy_d[rd_WB_in] = 1'b0;
      end
      if (issue && reg_write_D_in && long_lat_D_in && (rd_D_in != '0)) begin
        busy_d[rd_D_in] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // State and scoreboard registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  assign state_out = state_q;
  assign busy_out  = busy_q;

`ifdef HAZARD_PERF_EN
  logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles in which fetch/decode are held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
    end else if (stall_fd_out && (stall_cnt_q != {PERF_WIDTH{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`else
  assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed cycle table plus randomized traffic,
// all compared against a behavioural scoreboard model.
module tb_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, rd_wb;
  logic        rw, ll, br, ms, rw_wb;
  logic        stall_fd, stall_ex, flush_d, flush_e;
  logic [1:0]  state;
  logic [31:0] busy;
  logic [31:0] stall_cnt;

  int n_checks;
  int n_fail;

  // Behavioural model state.
  bit   busy_m [32];
  int   state_m;
  longint cnt_m;

  hazard_scoreboard #(
    .NUM_REGS  (32),
    .REG_BITS  (5),
    .PERF_WIDTH(32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .rs1_D_in         (rs1),
    .rs2_D_in         (rs2),
    .rd_D_in          (rd),
    .reg_write_D_in   (rw),
    .long_lat_D_in    (ll),
    .branch_taken_E_in(br),
    .mem_stall_in     (ms),
    .rd_WB_in         (rd_wb),
    .reg_write_WB_in  (rw_wb),
    .stall_fd_out     (stall_fd),
    .stall_ex_out     (stall_ex),
    .flush_d_out      (flush_d),
    .flush_e_out      (flush_e),
    .state_out        (state),
    .busy_out         (busy),
    .stall_cnt_out    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, ll, br, ms;
    logic [4:0]  rdwb;
    logic        rwwb;
    logic [3:0]  exp_ctl;   // {stall_fd, stall_ex, flush_d, flush_e}
    logic [1:0]  exp_st;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic rst_v, logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                              logic w, logic l, logic b, logic m, logic [4:0] dwb, logic wwb,
                              logic [3:0] ctl, logic [1:0] st, logic [31:0] bz);
    vec_t v;
    v.rst = rst_v; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.rw = w; v.ll = l; v.br = b; v.ms = m;
    v.rdwb = dwb; v.rwwb = wwb; v.exp_ctl = ctl; v.exp_st = st; v.exp_busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  // Expected controls from the priority rules, using the model scoreboard.
  function automatic logic [3:0] model_ctl();
    bit haz;
    haz = busy_m[rs1] || busy_m[rs2] || (rw && busy_m[rd]);
    if (reset)      return 4'b0000;
    if (ms)         return 4'b1100;
    if (br)         return 4'b0011;
    if (haz)        return 4'b1001;
    return 4'b0000;
  endfunction

  function automatic int model_next_state();
    bit haz;
    haz = busy_m[rs1] || busy_m[rs2] || (rw && busy_m[rd]);
    if (reset) return 0;
    if (ms)    return 2;
    if (br)    return 0;
    if (haz)   return 1;
    return 0;
  endfunction

  task automatic model_clock();
    logic [3:0] ctl;
    bit issue;
    int nst;
    ctl = model_ctl();
    nst = model_next_state();
    issue = !reset && !ctl[3] && !ctl[1];
    if (reset) begin
      for (int i = 0; i < 32; i++) busy_m[i] = 0;
      state_m = 0;
      cnt_m = 0;
    end else begin
      if (rw_wb && !ms) busy_m[rd_wb] = 0;
      if (issue && rw && ll && rd != 0) busy_m[rd] = 1;
      state_m = nst;
`ifdef HAZARD_PERF_EN
      if (ctl[3] && cnt_m < 64'hFFFF_FFFF) cnt_m++;
`endif
    end
  endtask

  // Drive one cycle of inputs, check mid-cycle against the model, then advance.
  task automatic step(input logic rst_v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic w, input logic l, input logic b,
                      input logic m, input logic [4:0] dwb, input logic wwb);
    logic [3:0] ctl;
    reset = rst_v; rs1 = s1; rs2 = s2; rd = d; rw = w; ll = l; br = b; ms = m;
    rd_wb = dwb; rw_wb = wwb;
    @(negedge clk);
    ctl = model_ctl();
    chk("stall_fd", {31'd0, stall_fd}, {31'd0, ctl[3]});
    chk("stall_ex", {31'd0, stall_ex}, {31'd0, ctl[2]});
    chk("flush_d",  {31'd0, flush_d},  {31'd0, ctl[1]});
    chk("flush_e",  {31'd0, flush_e},  {31'd0, ctl[0]});
    chk("state",    {30'd0, state},    state_m[31:0]);
    chk("busy",     busy,              model_busy_vec());
    chk("stall_cnt", stall_cnt,        cnt_m[31:0]);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) busy_m[i] = 0;
    state_m = 0;
    cnt_m = 0;

    // Directed load-use / x0 / branch / mem-stall / same-cycle / reset sequence.
    //             rst s1 s2 rd rw ll br ms wb wbv  ctl      st  busy
    vecs[0]  = mk(0, 1, 2, 5, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[1]  = mk(0, 5, 0, 6, 1, 0, 0, 0, 0, 0, 4'b1001, 0, 32'h20);
    vecs[2]  = mk(0, 5, 0, 6, 1, 0, 0, 0, 0, 0, 4'b1001, 1, 32'h20);
    vecs[3]  = mk(0, 5, 0, 6, 1, 0, 0, 0, 5, 1, 4'b1001, 1, 32'h20);
    vecs[4]  = mk(0, 5, 0, 6, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 32'h0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[6]  = mk(0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[8]  = mk(0, 1, 2, 7, 1, 1, 0, 0, 0, 0, 4'b0000, 0, 32'h0);
    vecs[9]  = mk(0, 7, 0, 7, 1, 1, 1, 0, 0, 0, 4'b0011, 0, 32'h80);
    vecs[10] = mk(0, 7, 0, 8, 1, 0, 0, 0, 0, 0, 4'b1001, 0, 32'h80);
    vecs[11] = mk(0, 7, 0, 8, 1, 0, 1, 1, 7, 1, 4'b1100, 1, 32'h80);
    vecs[12] = mk(0, 7, 0, 8, 1, 0, 1, 1, 7, 1, 4'b1100, 2, 32'h80);
    vecs[13] = mk(0, 7, 0, 8, 1, 0, 1, 1, 7, 1, 4'b1100, 2, 32'h80);
    vecs[14] = mk(0, 7, 0, 8, 1, 0, 0, 0, 7, 1, 4'b1001, 2, 32'h80);
    vecs[15] = mk(0, 7, 0, 8, 1, 0, 0, 0, 0, 0, 4'b0000, 1, 32'h0);
    vecs[16] = mk(0, 0, 0, 9, 1, 1, 0, 0, 9, 1, 4'b0000, 0, 32'h0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h200);
    vecs[18] = mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1001, 0, 32'h200);
    vecs[19] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 32'h200);
    vecs[20] = mk(0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'h0);

    reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; rw = 1'b0; ll = 1'b0; br = 1'b0; ms = 1'b0;
    rd_wb = '0; rw_wb = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_busy",  busy,              32'h0);
    chk("reset_state", {30'd0, state},    32'd0);
    chk("reset_cnt",   stall_cnt,         32'd0);
    chk("reset_ctl",   {28'd0, stall_fd, stall_ex, flush_d, flush_e}, 32'd0);

    for (int i = 0; i < 21; i++) begin
      reset = vecs[i].rst; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
      rw = vecs[i].rw; ll = vecs[i].ll; br = vecs[i].br; ms = vecs[i].ms;
      rd_wb = vecs[i].rdwb; rw_wb = vecs[i].rwwb;
      #2;
      chk($sformatf("vec%0d_ctl", i), {28'd0, stall_fd, stall_ex, flush_d, flush_e},
          {28'd0, vecs[i].exp_ctl});
      chk($sformatf("vec%0d_state", i), {30'd0, state}, {30'd0, vecs[i].exp_st});
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      step(vecs[i].rst, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw, vecs[i].ll,
           vecs[i].br, vecs[i].ms, vecs[i].rdwb, vecs[i].rwwb);
    end

`ifdef HAZARD_PERF_EN
    // Four RAW stall cycles then two memory stall cycles, counted from a fresh reset.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf_six", stall_cnt, 32'd6);
    step(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("perf_reset_cnt", stall_cnt, 32'd0);
    chk("perf_reset_busy", busy, 32'd0);
`endif

    // Randomized traffic on a small register window to provoke frequent conflicts.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
